spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
Parametrised SPI master: the next generation of the team's fixed 12-bit, mode-0, single-chip-select transmitter. It generalises frame width, clock divide, SPI mode (CPOL/CPHA), bit order and chip-select count. The whole block runs in one clock domain: sclk is a registered output driven from internal edge enables, and no logic is clocked by sclk. It sits between a local command source (newd/din handshake) and up to NUM_CS external SPI slaves.

Parameters:
DATA_W, 12, bits per frame (>=2)
HALF_DIV, 11, clk cycles per sclk half-period (>=1)
NUM_CS, 1, number of active-low chip selects (>=1)
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
LSB_FIRST, 1, 1 = bit 0 shifted first, 0 = bit DATA_W-1 first

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  synchronous, active-low reset
newd  in  1  start request; accepted only when busy=0
din  in  DATA_W  frame data, latched at acceptance
cs_sel  in  max(1,$clog2(NUM_CS))  target slave, latched at acceptance
sclk  out  1  SPI clock
mosi  out  1  serial data out
cs_n  out  NUM_CS  chip selects, active low
busy  out  1  high from the cycle after acceptance until the done cycle (exclusive)
done  out  1  one-cycle end-of-frame pulse
miso  in  1  (SPI_RX_EN only) serial data in
dout  out  DATA_W  (SPI_RX_EN only) received frame

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst=0 sampled at posedge clk).
- Reset values: sclk=CPOL, mosi=0, cs_n=all 1s, busy=0, done=0, dout=0, FSM=IDLE, all counters 0.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - sclk=CPOL, cs_n all high.
  - newd=1 latches din and cs_sel into shift/select registers and moves to SETUP.
- SETUP (HALF_DIV cycles):
  - cs_n[cs_sel]=0.
  - CPHA=0: first bit is driven on mosi on entry.
  - CPHA=1: mosi holds its previous value.
- SHIFT:
  - sclk toggles every HALF_DIV cycles, 2*DATA_W edges in total; odd-numbered edges are leading, even-numbered edges are trailing.
  - CPHA=0: sample on leading edges; drive the next bit on trailing edges, except after the last one.
  - CPHA=1: drive the next bit on leading edges; sample on trailing edges.
  - Bit order follows LSB_FIRST.
- HOLD (HALF_DIV cycles):
  - sclk=CPOL; chip select stays low.
  - Then cs_n returns to all high, mosi=0, done=1 for one cycle, busy=0, FSM returns to IDLE.
- Timing: done is high in the cycle following the ((2*DATA_W+1)*HALF_DIV)-th posedge after the acceptance edge. Defaults give 275 cycles.
- Back-to-back frames: newd=1 during the done cycle is accepted. cs_n is then high for exactly 1 cycle between frames.
- newd and din changes while busy=1 are ignored and have no effect on the frame in flight.
- cs_sel >= NUM_CS: the frame runs with full timing but no cs_n is asserted.
- Reset mid-frame: the frame aborts. All outputs take reset values at that edge and no done is issued.

Optional Feature:
Macro SPI_RX_EN.
- Defined: miso and dout ports exist. miso is sampled on every sample edge and assembled in the same bit order as transmission. dout updates in the done cycle and holds until the next done or reset.
- Undefined: no miso/dout ports and no receive logic; transmit timing is identical.

Test Plan:
1. Reset: rst=0 for 3 cycles mid-idle -> sclk=CPOL, mosi=0, cs_n=all 1s, busy=0, done=0.
2. Defaults, din=12'hA5C, newd pulse -> mosi sampled at rising sclk = 0,0,1,1,1,0,1,0,0,1,0,1. Exactly 12 rising edges, cs_n[0] low throughout, done at cycle 275 after acceptance.
3. DATA_W=8, HALF_DIV=2, CPOL=1, CPHA=1, LSB_FIRST=0, din=8'h96 -> bits sampled at rising (trailing) edges = 1,0,0,1,0,1,1,0. sclk idles high, done at cycle 34.
4. newd held high, din changed mid-frame -> the in-flight frame is unaffected, the second frame is accepted on the done cycle, and cs_n is high for exactly 1 cycle between frames.
5. rst=0 after 5 bits -> cs_n high and sclk=CPOL at that edge, no done. A following frame with din=12'h001 completes normally.
6. SPI_RX_EN, NUM_CS=4, miso tied to mosi, cs_sel=2, din=12'h3C7 -> only cs_n[2] low, dout=12'h3C7 in the done cycle.

Source files
------------

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one clock domain, sclk is a registered output stepped by edge enables.
// Define SPI_RX_EN to add the miso/dout receive path; the default build is transmit-only.
module spi_master_param #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned HALF_DIV  = 11,
  parameter int unsigned NUM_CS    = 1,
  parameter int unsigned CPOL      = 0,
  parameter int unsigned CPHA      = 0,
  parameter int unsigned LSB_FIRST = 1,
  localparam int unsigned CsW      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic [DATA_W-1:0] din,
  input  logic [CsW-1:0]    cs_sel,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic              busy,
  output logic              done
`ifdef SPI_RX_EN
  ,
  input  logic              miso,
  output logic [DATA_W-1:0] dout
`endif
);

  localparam int unsigned CntW  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned EdgeW = $clog2(2 * DATA_W + 1);

  localparam logic [CntW-1:0]  CntMax   = CntW'(HALF_DIV - 1);
  localparam logic [EdgeW-1:0] EdgeLast = EdgeW'(2 * DATA_W - 1);
  localparam logic             IdleLvl  = (CPOL != 0);
  localparam bit               Cpha     = (CPHA != 0);
  localparam bit               Lsb      = (LSB_FIRST != 0);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [EdgeW-1:0]    edge_q, edge_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic [NUM_CS-1:0]   cs_q, cs_d;
  logic                done_q, done_d;
  logic [NUM_CS-1:0]   cs_dec;
  logic                half_end, do_edge, leading, last_edge, drive;
`ifdef SPI_RX_EN
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                sample;
`endif

  function automatic logic out_bit(input logic [DATA_W-1:0] v);
    return Lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
    return Lsb ? (v >> 1) : (v << 1);
  endfunction

  // Out-of-range selects decode to all-high, so the frame runs with no slave addressed.
  always_comb begin
    cs_dec = '1;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CsW'(i)) cs_dec[i] = 1'b0;
    end
  end

  assign half_end  = (cnt_q == CntMax);
  assign do_edge   = half_end && ((state_q == StSetup) || (state_q == StShift));
  assign leading   = ~edge_q[0];
  assign last_edge = (edge_q == EdgeLast);
  // CPHA=0 pre-loads bit 0 at acceptance, so it only drives on trailing edges (not the final one).
  assign drive     = Cpha ? leading : (~leading & ~last_edge);
`ifdef SPI_RX_EN
  assign sample    = Cpha ? ~leading : leading;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    sh_d    = sh_q;
    mosi_d  = mosi_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    done_d  = 1'b0;
`ifdef SPI_RX_EN
    rx_d    = rx_q;
    dout_d  = dout_q;
`endif

    unique case (state_q)
      StIdle: begin
        sclk_d = IdleLvl;
        cs_d   = '1;
        cnt_d  = '0;
        edge_d = '0;
        if (newd) begin
          state_d = StSetup;
          cs_d    = cs_dec;
          if (Cpha) begin
            sh_d = din;
          end else begin
            mosi_d = out_bit(din);
            sh_d   = advance(din);
          end
        end
      end
      StSetup: begin
        cnt_d = half_end ? '0 : cnt_q + CntW'(1);
        if (half_end) state_d = StShift;
      end
      StShift: begin
        cnt_d = half_end ? '0 : cnt_q + CntW'(1);
        if (half_end && last_edge) state_d = StHold;
      end
      StHold: begin
        sclk_d = IdleLvl;
        if (half_end) begin
          state_d = StIdle;
          cnt_d   = '0;
          cs_d    = '1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
`ifdef SPI_RX_EN
          dout_d  = rx_q;
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // The first sclk edge coincides with leaving SETUP; the rest fall inside SHIFT.
    if (do_edge) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + EdgeW'(1);
      if (drive) begin
        mosi_d = out_bit(sh_q);
        sh_d   = advance(sh_q);
      end
`ifdef SPI_RX_EN
      if (sample) rx_d = Lsb ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      edge_q  <= '0;
      sh_q    <= '0;
      mosi_q  <= 1'b0;
      sclk_q  <= IdleLvl;
      cs_q    <= '1;
      done_q  <= 1'b0;
`ifdef SPI_RX_EN
      rx_q    <= '0;
      dout_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      sh_q    <= sh_d;
      mosi_q  <= mosi_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      done_q  <= done_d;
`ifdef SPI_RX_EN
      rx_q    <= rx_d;
      dout_q  <= dout_d;
`endif
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_q;
  assign busy = (state_q != StIdle);
  assign done = done_q;
`ifdef SPI_RX_EN
  assign dout = dout_q;
`endif

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: default instance plus an 8-bit CPOL=1/CPHA=1/MSB-first, 4-CS instance.
// Frames are checked against bit-order, latency and chip-select rules computed in the bench.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst    = 1'b0;
  logic        newd   = 1'b0;
  logic        which  = 1'b0;
  logic [11:0] din    = '0;
  logic [1:0]  cs_sel = '0;

  logic        newd_a, newd_b;
  logic        sclk_a, mosi_a, busy_a, done_a;
  logic [0:0]  cs_n_a;
  logic        sclk_b, mosi_b, busy_b, done_b;
  logic [3:0]  cs_n_b;
  logic        obs_sclk, obs_mosi, obs_busy, obs_done;
  logic [3:0]  obs_cs;

  int checks   = 0;
  int failures = 0;

  assign newd_a = newd & ~which;
  assign newd_b = newd & which;

`ifdef SPI_RX_EN
  logic [11:0] dout_a;
  logic [7:0]  dout_b;
  logic [11:0] obs_dout;
  assign obs_dout = which ? {4'b0, dout_b} : dout_a;
`endif

  spi_master_param u_a (
    .clk    (clk),
    .rst    (rst),
    .newd   (newd_a),
    .din    (din),
    .cs_sel (cs_sel[0:0]),
    .sclk   (sclk_a),
    .mosi   (mosi_a),
    .cs_n   (cs_n_a),
    .busy   (busy_a),
    .done   (done_a)
`ifdef SPI_RX_EN
    ,
    .miso   (mosi_a),
    .dout   (dout_a)
`endif
  );

  spi_master_param #(
    .DATA_W    (8),
    .HALF_DIV  (2),
    .NUM_CS    (4),
    .CPOL      (1),
    .CPHA      (1),
    .LSB_FIRST (0)
  ) u_b (
    .clk    (clk),
    .rst    (rst),
    .newd   (newd_b),
    .din    (din[7:0]),
    .cs_sel (cs_sel),
    .sclk   (sclk_b),
    .mosi   (mosi_b),
    .cs_n   (cs_n_b),
    .busy   (busy_b),
    .done   (done_b)
`ifdef SPI_RX_EN
    ,
    .miso   (mosi_b),
    .dout   (dout_b)
`endif
  );

  assign obs_sclk = which ? sclk_b : sclk_a;
  assign obs_mosi = which ? mosi_b : mosi_a;
  assign obs_busy = which ? busy_b : busy_a;
  assign obs_done = which ? done_b : done_a;
  assign obs_cs   = which ? cs_n_b : {3'b111, cs_n_a};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a posedge with the selected instance idle; returns #1 after the acceptance edge.
  task automatic start(input logic [11:0] d, input logic [1:0] sel);
    newd   = 1'b1;
    din    = d;
    cs_sel = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [11:0] d, input logic [1:0] sel, input bit chain,
                           input logic [11:0] d2);
    int          dw, hd, ncs, lat, rises, done_at;
    bit          lsb, cs_ok;
    logic        cpol, prev_sclk;
    logic [11:0] got, expb, mask;
    logic [3:0]  exp_cs;
    dw   = which ? 8 : 12;
    hd   = which ? 2 : 11;
    ncs  = which ? 4 : 1;
    lsb  = !which;
    cpol = which;
    lat  = (2 * dw + 1) * hd;
    mask = 12'((1 << dw) - 1);
    expb = '0;
    for (int i = 0; i < dw; i++) expb[i] = lsb ? d[i] : d[dw-1-i];
    exp_cs = 4'hF;
    if (int'(sel) < ncs) exp_cs[sel] = 1'b0;

    chk("busy_after_accept", obs_busy, 1);
    chk("cs_after_accept", obs_cs, exp_cs);
    if (!chain) newd = 1'b0;
    din    = 12'($urandom);
    cs_sel = 2'($urandom);
    rises = 0; got = '0; done_at = -1; cs_ok = 1'b1; prev_sclk = obs_sclk;
    for (int k = 1; k <= lat + 20; k++) begin
      @(posedge clk);
      #1;
      if (chain && k == lat / 2) begin
        din    = d2;
        cs_sel = sel;
      end
      if (obs_done) begin
        done_at = k;
        break;
      end
      if (obs_cs !== exp_cs) cs_ok = 1'b0;
      if (!prev_sclk && obs_sclk) begin
        if (rises < 12) got[rises] = obs_mosi;
        rises++;
      end
      prev_sclk = obs_sclk;
    end
    chk("done_latency", done_at, lat);
    chk("rising_edges", rises, dw);
    chk("bits_sampled", got, expb);
    chk("cs_during_frame", cs_ok, 1);
    chk("cs_at_done", obs_cs, 4'hF);
    chk("busy_at_done", obs_busy, 0);
    chk("mosi_at_done", obs_mosi, 0);
    chk("sclk_at_done", obs_sclk, cpol);
`ifdef SPI_RX_EN
    chk("dout_at_done", obs_dout, d & mask);
`endif
    @(posedge clk);
    #1;
    if (chain) begin
      chk("chain_cs_low_again", obs_cs, exp_cs);
      chk("chain_busy", obs_busy, 1);
    end else begin
      chk("done_one_cycle", obs_done, 0);
      chk("cs_idle", obs_cs, 4'hF);
    end
  endtask

  initial begin
    int          rises, dones;
    logic        prev_sclk;
    logic [11:0] d1, d2;
    logic [1:0]  s;

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sclk_a", sclk_a, 0);
    chk("rst_sclk_b", sclk_b, 1);
    chk("rst_mosi", {mosi_a, mosi_b}, 0);
    chk("rst_cs_a", cs_n_a, 1);
    chk("rst_cs_b", cs_n_b, 4'hF);
    chk("rst_busy", {busy_a, busy_b}, 0);
    chk("rst_done", {done_a, done_b}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    which = 1'b0;
    start(12'hA5C, 2'd0);
    run_frame(12'hA5C, 2'd0, 1'b0, 12'h0);

    which = 1'b1;
    start(12'h096, 2'd2);
    run_frame(12'h096, 2'd2, 1'b0, 12'h0);
    for (int n = 0; n < 3; n++) begin
      d1 = 12'($urandom_range(0, 255));
      s  = 2'($urandom_range(0, 3));
      start(d1, s);
      run_frame(d1, s, 1'b0, 12'h0);
    end
    d1 = 12'($urandom_range(0, 255));
    d2 = 12'($urandom_range(0, 255));
    start(d1, 2'd3);
    run_frame(d1, 2'd3, 1'b1, d2);
    run_frame(d2, 2'd3, 1'b0, 12'h0);

    which = 1'b0;
    for (int n = 0; n < 2; n++) begin
      d1 = 12'($urandom);
      s  = 2'($urandom_range(0, 1));
      start(d1, s);
      run_frame(d1, s, 1'b0, 12'h0);
    end
    d1 = 12'($urandom);
    d2 = 12'($urandom);
    start(d1, 2'd0);
    run_frame(d1, 2'd0, 1'b1, d2);
    run_frame(d2, 2'd0, 1'b0, 12'h0);

    // Abort after five bits, then a clean frame.
    start(12'h5A3, 2'd0);
    newd = 1'b0;
    rises = 0;
    prev_sclk = sclk_a;
    for (int k = 0; k < 400 && rises < 5; k++) begin
      @(posedge clk);
      #1;
      if (!prev_sclk && sclk_a) rises++;
      prev_sclk = sclk_a;
    end
    chk("abort_bits_reached", rises, 5);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs", cs_n_a, 1);
    chk("abort_sclk", sclk_a, 0);
    chk("abort_mosi", mosi_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    rst = 1'b1;
    dones = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (done_a) dones++;
    end
    chk("abort_no_done", dones, 0);
    start(12'h001, 2'd0);
    run_frame(12'h001, 2'd0, 1'b0, 12'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
